daq_frame_tx: RTL and testbench



---
 rtl/daq_frame_tx.sv | 247 ++++++++++++++++++++++++
 tb/tb_daq_frame_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_frame_tx.sv
// daq_frame_tx: buffers 16-bit event word streams in a FIFO. Each complete
// event is re-sent on the optical link as one frame: SOF, data words,
// CRC-16, EOF. Comma IDLE words fill the link between frames, and TXACK
// pulses while EOF is on the link.
//
// Parameters
//   AW        FIFO address width; depth 2^AW entries of {last, data[15:0]}
//   IDLE_MIN  minimum IDLE words between EOF and the next SOF (1..15)
// Ports
//   CLK       system clock, rising edge
//   RST       asynchronous active-low reset
//   DIN       event data word, qualified by VALID
//   VALID     write DIN into the FIFO
//   LAST_WRD  DIN is the final word of the event (qualified by VALID)
//   CLR_CRC   start-of-event strobe; restarts the write-side word count
//   LINK_RDY  link up; a frame may start only while high
//   TXD/TXK   registered link word and per-byte K flags
//   TXACK     one-cycle pulse while EOF is on TXD
//   FULL      occupancy >= 2^AW-1
//   OVFL      sticky dropped-word flag
//   EVT_CNT   frames sent, wrapping
//   TX_STATE  transmit state code
module daq_frame_tx #(
  parameter int unsigned AW       = 10,
  parameter int unsigned IDLE_MIN = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DIN,
  input  logic        VALID,
  input  logic        LAST_WRD,
  input  logic        CLR_CRC,
  input  logic        LINK_RDY,
  output logic [15:0] TXD,
  output logic [1:0]  TXK,
  output logic        TXACK,
  output logic        FULL,
  output logic        OVFL,
  output logic [15:0] EVT_CNT,
  output logic [2:0]  TX_STATE
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam int unsigned CW       = AW + 1;
  localparam int unsigned FULL_LVL = DEPTH - 1;

  localparam logic [15:0] W_IDLE   = 16'h50BC;
  localparam logic [15:0] W_SOF    = 16'hF7FB;
  localparam logic [15:0] W_EOF    = 16'hFDFE;
  localparam logic [1:0]  K_IDLE   = 2'b01;
  localparam logic [1:0]  K_CTRL   = 2'b11;
  localparam logic [1:0]  K_DATA   = 2'b00;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [3:0]  GAP_MAX  = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_CRC  = 3'd3,
    ST_EOF  = 3'd4
  } state_e;

  // CRC-16/0x1021 update for one word, MSB first
  function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                           input logic [15:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // FIFO storage and bookkeeping
  logic [16:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  pend_q, pend_d;
  logic           last_wr_q;
  logic [15:0]    evt_words_q, evt_words_d;
  logic           full_q, ovfl_q;

  // Transmit side
  state_e         state_q, state_d;
  logic [15:0]    txd_q, txd_d;
  logic [1:0]     txk_q, txk_d;
  logic           txack_q, txack_d;
  logic [15:0]    crc_q, crc_d;
  logic           last_q, last_d;
  logic [3:0]     gap_q, gap_d;
  logic [15:0]    evt_cnt_q, evt_cnt_d;

  logic           wr_en, drop, pop, sof_start;
  logic           fifo_empty;
  logic [16:0]    rd_word;
  logic [15:0]    rd_data;
  logic           rd_last;

  assign fifo_empty = (count_q == '0);
  assign rd_word    = mem_q[rd_ptr_q];
  assign rd_data    = fifo_empty ? 16'h0000 : rd_word[15:0];
  // An empty FIFO ends the frame rather than running past the data
  assign rd_last    = fifo_empty | rd_word[16];

  // Write admission: the last free slot is reserved for an event's last word
  always_comb begin
    wr_en = 1'b0;
    drop  = 1'b0;
    if (VALID) begin
      if ((count_q < CW'(FULL_LVL)) ||
          ((count_q == CW'(FULL_LVL)) && LAST_WRD)) begin
        wr_en = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy, pending frames and write-side word count
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(wr_en) - CW'(pop);
    // Last-word credit is delayed one cycle so SOF trails the write by two edges
    pend_d   = pend_q + CW'(last_wr_q) - CW'(sof_start);
    evt_words_d = evt_words_q;
    if (CLR_CRC) evt_words_d = 16'(wr_en);
    else if (wr_en) evt_words_d = evt_words_q + 16'd1;
  end

  // FIFO data array, no reset needed
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= {LAST_WRD, DIN};
  end

  // Transmit FSM next-state and registered-output values
  always_comb begin
    state_d   = state_q;
    txd_d     = W_IDLE;
    txk_d     = K_IDLE;
    txack_d   = 1'b0;
    crc_d     = crc_q;
    last_d    = last_q;
    gap_d     = gap_q;
    evt_cnt_d = evt_cnt_q;
    pop       = 1'b0;
    sof_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // gap_q counts IDLE words on the link since the last EOF
        if (gap_q != GAP_MAX) gap_d = gap_q + 4'd1;
        if ((pend_q != '0) && LINK_RDY && (gap_q >= 4'(IDLE_MIN))) begin
          state_d   = ST_SOF;
          txd_d     = W_SOF;
          txk_d     = K_CTRL;
          sof_start = 1'b1;
        end
      end
      ST_SOF: begin
        state_d = ST_DATA;
        pop     = ~fifo_empty;
        txd_d   = rd_data;
        txk_d   = K_DATA;
        crc_d   = crc_step(CRC_INIT, rd_data);
        last_d  = rd_last;
      end
      ST_DATA: begin
        if (last_q) begin
          state_d = ST_CRC;
          txd_d   = crc_q;
          txk_d   = K_DATA;
        end else begin
          pop    = ~fifo_empty;
          txd_d  = rd_data;
          txk_d  = K_DATA;
          crc_d  = crc_step(crc_q, rd_data);
          last_d = rd_last;
        end
      end
      ST_CRC: begin
        state_d   = ST_EOF;
        txd_d     = W_EOF;
        txk_d     = K_CTRL;
        txack_d   = 1'b1;
        evt_cnt_d = evt_cnt_q + 16'd1;
      end
      ST_EOF: begin
        state_d = ST_IDLE;
        gap_d   = 4'd1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      last_wr_q   <= 1'b0;
      evt_words_q <= 16'h0000;
      full_q      <= 1'b0;
      ovfl_q      <= 1'b0;
      state_q     <= ST_IDLE;
      txd_q       <= W_IDLE;
      txk_q       <= K_IDLE;
      txack_q     <= 1'b0;
      crc_q       <= CRC_INIT;
      last_q      <= 1'b0;
      gap_q       <= GAP_MAX;
      evt_cnt_q   <= 16'h0000;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      last_wr_q   <= wr_en & LAST_WRD;
      evt_words_q <= evt_words_d;
      full_q      <= (count_d >= CW'(FULL_LVL));
      ovfl_q      <= ovfl_q | drop;
      state_q     <= state_d;
      txd_q       <= txd_d;
      txk_q       <= txk_d;
      txack_q     <= txack_d;
      crc_q       <= crc_d;
      last_q      <= last_d;
      gap_q       <= gap_d;
      evt_cnt_q   <= evt_cnt_d;
    end
  end

  assign TXD      = txd_q;
  assign TXK      = txk_q;
  assign TXACK    = txack_q;
  assign FULL     = full_q;
  assign OVFL     = ovfl_q;
  assign EVT_CNT  = evt_cnt_q;
  assign TX_STATE = state_q;

endmodule

// File: tb/tb_daq_frame_tx.sv
// Testbench for daq_frame_tx with a 16-entry FIFO and a three-word idle gap.
module tb_daq_frame_tx;

  localparam int unsigned AW       = 4;
  localparam int unsigned IDLE_MIN = 3;

  localparam logic [15:0] W_IDLE = 16'h50BC;
  localparam logic [15:0] W_SOF  = 16'hF7FB;
  localparam logic [15:0] W_EOF  = 16'hFDFE;

  typedef logic [15:0] wq_t[$];

  logic        CLK;
  logic        RST;
  logic [15:0] DIN;
  logic        VALID;
  logic        LAST_WRD;
  logic        CLR_CRC;
  logic        LINK_RDY;
  logic [15:0] TXD;
  logic [1:0]  TXK;
  logic        TXACK;
  logic        FULL;
  logic        OVFL;
  logic [15:0] EVT_CNT;
  logic [2:0]  TX_STATE;

  int n_checks = 0;
  int n_errors = 0;
  int exp_evt  = 0;

  daq_frame_tx #(.AW(AW), .IDLE_MIN(IDLE_MIN)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .VALID(VALID), .LAST_WRD(LAST_WRD),
    .CLR_CRC(CLR_CRC), .LINK_RDY(LINK_RDY), .TXD(TXD), .TXK(TXK),
    .TXACK(TXACK), .FULL(FULL), .OVFL(OVFL), .EVT_CNT(EVT_CNT),
    .TX_STATE(TX_STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference CRC: XOR the word into the register, then 16 polynomial steps
  function automatic logic [15:0] model_crc(input wq_t w);
    logic [15:0] crc;
    crc = 16'hFFFF;
    foreach (w[i]) begin
      crc = crc ^ w[i];
      for (int b = 0; b < 16; b++)
        crc = crc[15] ? ((crc << 1) ^ 16'h1021) : (crc << 1);
    end
    return crc;
  endfunction

  function automatic logic [31:0] lw(input logic [15:0] d, input logic [1:0] k,
                                     input logic [2:0] st, input logic ack);
    return {10'd0, ack, st, k, d};
  endfunction

  function automatic logic [31:0] link_now();
    return lw(TXD, TXK, TX_STATE, TXACK);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [15:0] d, input logic last, input logic clr);
    @(negedge CLK);
    VALID = 1'b1; DIN = d; LAST_WRD = last; CLR_CRC = clr;
  endtask

  task automatic idle_in();
    @(negedge CLK);
    VALID = 1'b0; DIN = 16'h0000; LAST_WRD = 1'b0; CLR_CRC = 1'b0;
  endtask

  task automatic write_event(input wq_t w);
    foreach (w[i]) write_word(w[i], (i == w.size() - 1), (i == 0));
    idle_in();
  endtask

  // Wait for SOF (IDLE required meanwhile), then check the whole frame
  task automatic frame_check(input wq_t w, input int exp_lat, input int exp_idles);
    int   waited = 0;
    int   idles  = 0;
    bit   found  = 1'b0;
    logic [15:0] crc;
    crc = model_crc(w);
    for (int i = 1; i <= 60 && !found; i++) begin
      @(negedge CLK);
      waited = i;
      if (TXD === W_SOF && TXK === 2'b11) found = 1'b1;
      else begin
        idles++;
        check("idle_word", link_now(), lw(W_IDLE, 2'b01, 3'd0, 1'b0));
      end
    end
    check("sof_found", 32'(found), 32'd1);
    if (found) begin
      if (exp_lat >= 0)   check("sof_latency", 32'(waited), 32'(exp_lat));
      if (exp_idles >= 0) check("idle_gap", 32'(idles), 32'(exp_idles));
      check("sof", link_now(), lw(W_SOF, 2'b11, 3'd1, 1'b0));
      foreach (w[i]) begin
        @(negedge CLK);
        check("data", link_now(), lw(w[i], 2'b00, 3'd2, 1'b0));
      end
      @(negedge CLK);
      check("crc", link_now(), lw(crc, 2'b00, 3'd3, 1'b0));
      @(negedge CLK);
      exp_evt++;
      check("eof", link_now(), lw(W_EOF, 2'b11, 3'd4, 1'b1));
      check("evt_cnt", 32'(EVT_CNT), 32'(16'(exp_evt)));
    end
  endtask

  initial begin
    wq_t q1, q2;
    int  n;
    bit  seen;

    RST = 1'b0; DIN = 16'h0000; VALID = 1'b0; LAST_WRD = 1'b0;
    CLR_CRC = 1'b0; LINK_RDY = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_link", link_now(), lw(W_IDLE, 2'b01, 3'd0, 1'b0));
    check("reset_flags", {14'd0, FULL, OVFL, EVT_CNT}, 32'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Single zero word: CRC 1D0F, SOF two edges after the write
    q1 = {};
    q1.push_back(16'h0000);
    write_event(q1);
    frame_check(q1, 2, -1);

    // 8-word event 1..8
    q1 = {};
    for (int i = 1; i <= 8; i++) q1.push_back(16'(i));
    write_event(q1);
    frame_check(q1, 2, -1);

    // Back-to-back events: exactly IDLE_MIN idles between frames
    q1 = {}; q2 = {};
    for (int i = 0; i < 3; i++) begin
      q1.push_back(16'($urandom));
      q2.push_back(16'($urandom));
    end
    write_event(q1);
    fork
      write_event(q2);
      begin
        frame_check(q1, 2, -1);
        frame_check(q2, -1, 3);
      end
    join

    // Link down holds the frame; SOF one cycle after link up
    LINK_RDY = 1'b0;
    q1 = {};
    for (int i = 0; i < 4; i++) q1.push_back(16'($urandom));
    write_event(q1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("link_down_idle", link_now(), lw(W_IDLE, 2'b01, 3'd0, 1'b0));
    end
    LINK_RDY = 1'b1;
    frame_check(q1, 1, -1);

    // Link drop mid-frame does not abort the frame
    q1 = {};
    for (int i = 0; i < 6; i++) q1.push_back(16'($urandom));
    write_event(q1);
    fork
      begin repeat (4) @(negedge CLK); LINK_RDY = 1'b0; end
      frame_check(q1, 2, -1);
    join
    LINK_RDY = 1'b1;

    // Randomised events with random spacing
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 7);
      q1 = {};
      for (int i = 0; i < n; i++) q1.push_back(16'($urandom));
      repeat ($urandom_range(0, 4)) idle_in();
      write_event(q1);
      frame_check(q1, -1, -1);
    end

    // FIFO fill: reserved last slot, then overflow
    LINK_RDY = 1'b0;
    q1 = {};
    for (int i = 0; i < 15; i++) begin
      write_word(16'h0100 + 16'(i), 1'b0, (i == 0));
      q1.push_back(16'h0100 + 16'(i));
    end
    idle_in();
    check("full_at_15", {30'd0, FULL, OVFL}, 32'd2);
    write_word(16'h010F, 1'b1, 1'b0);
    q1.push_back(16'h010F);
    idle_in();
    check("last_in_reserved", {30'd0, FULL, OVFL}, 32'd2);
    write_word(16'hDEAD, 1'b0, 1'b0);
    idle_in();
    check("ovfl_set", {30'd0, FULL, OVFL}, 32'd3);
    LINK_RDY = 1'b1;
    frame_check(q1, -1, -1);
    check("drained_flags", {30'd0, FULL, OVFL}, 32'd1);

    // Asynchronous reset in the middle of a frame
    q1 = {};
    for (int i = 0; i < 8; i++) q1.push_back(16'($urandom));
    write_event(q1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (TX_STATE === 3'd2) seen = 1'b1;
    end
    check("reach_data", 32'(seen), 32'd1);
    #2 RST = 1'b0;
    #1 check("reset_async", link_now(), lw(W_IDLE, 2'b01, 3'd0, 1'b0));
    exp_evt = 0;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check("post_reset_idle", link_now(), lw(W_IDLE, 2'b01, 3'd0, 1'b0));
    end
    check("post_reset_flags", {14'd0, FULL, OVFL, EVT_CNT}, 32'd0);
    q1 = {};
    q1.push_back(16'hABCD);
    write_event(q1);
    frame_check(q1, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
